// File: rtl/beat_step_clock_pkg.sv
// Shared constants and helpers for the beat/step tempo generator.
// Width helpers derive the clog2 sizes from the top-level parameters.
package beat_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int unsigned pre_w(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic int unsigned idx_w(input int unsigned steps);
    return (steps < 2) ? 1 : $clog2(steps);
  endfunction

  // Swing is clamped to P-1 so odd steps never shrink below one tick.
  function automatic logic [31:0] step_len(input logic [31:0] period, input logic [31:0] swing,
                                           input logic odd);
    logic [31:0] p;
    logic [31:0] s;
    p = (period == 32'd0) ? 32'd1 : period;
    s = (swing > p - 32'd1) ? p - 32'd1 : swing;
    return odd ? p - s : p + s;
  endfunction

endpackage

// File: rtl/beat_step_clock_if.sv
// Control and trigger bundle between the tempo generator and its client.
interface beat_step_clock_if #(
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned STEPS    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 4
);
  import beat_pkg::*;

  localparam int unsigned IDX_W = idx_w(STEPS);

  logic                      RUN;
  logic [PERIOD_W-1:0]       PERIOD;
  logic [PERIOD_W-1:0]       SWING;
  logic [CHANNELS*DIV_W-1:0] CH_DIV;
  logic                      TICK;
  logic                      STEP_PULSE;
  logic [IDX_W-1:0]          STEP_INDEX;
  logic                      BEAT_CLOCK;
  logic [CHANNELS-1:0]       CH_PULSE;

  modport master (
    output RUN, PERIOD, SWING, CH_DIV,
    input  TICK, STEP_PULSE, STEP_INDEX, BEAT_CLOCK, CH_PULSE
  );

  modport slave (
    input  RUN, PERIOD, SWING, CH_DIV,
    output TICK, STEP_PULSE, STEP_INDEX, BEAT_CLOCK, CH_PULSE
  );

endinterface

// File: rtl/beat_step_clock_tick_prescaler.sv
// Base-tick divider: counts 0..DIV-1 and emits a registered pulse on wrap.
module tick_prescaler #(
  parameter int unsigned DIV = 10,
  parameter int unsigned W   = 4
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic CLR,
  output logic TICK
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         r_tick;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (CLR) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign TICK = r_tick;

endmodule

// File: rtl/beat_step_clock.sv
// Tempo generator: base tick -> swung sequencer steps, beat square wave and
// per-channel divided triggers. All outputs registered.
module beat_step_clock #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 100,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned STEPS    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 4
) (
  input logic              CLOCK_50,
  input logic              RESET_N,
  beat_step_clock_if.slave bus
);
  import beat_pkg::*;

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PRE_W    = pre_w(TICK_DIV);
  localparam int unsigned IDX_W    = idx_w(STEPS);
  localparam int unsigned LEN_W    = PERIOD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  state_e             r_state, w_state_d;
  logic               w_start, w_step, w_tick, w_clr, w_len_odd;
  logic [LEN_W-1:0]   r_tick_cnt, r_len, w_tick_cnt_inc;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic               r_beat, r_step_pulse;
  logic [CHANNELS-1:0] w_ch_pulse;

  // Prescaler phase restarts on the start edge and is held while stopped.
  assign w_clr = !bus.RUN || w_start;

  tick_prescaler #(
    .DIV (TICK_DIV),
    .W   (PRE_W)
  ) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .CLR      (w_clr),
    .TICK     (w_tick)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  w_state_d = bus.RUN ? StRun : StIdle;
      StRun:   w_state_d = bus.RUN ? StRun : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_tick_cnt_inc = r_tick_cnt + 1'b1;

  always_comb begin
    w_start = 1'b0;
    w_step  = 1'b0;
    unique case (r_state)
      StIdle:  w_start = bus.RUN;
      StRun:   w_step  = bus.RUN && w_tick && (w_tick_cnt_inc == r_len);
      default: ;
    endcase
  end

  assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  assign w_len_odd  = w_start ? 1'b0 : w_idx_next[0];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tick_cnt   <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_beat       <= 1'b0;
      r_step_pulse <= 1'b0;
    end else if (!bus.RUN) begin
      r_tick_cnt   <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_beat       <= 1'b0;
      r_step_pulse <= 1'b0;
    end else if (w_start || w_step) begin
      r_tick_cnt   <= '0;
      r_len        <= LEN_W'(step_len(32'(bus.PERIOD), 32'(bus.SWING), w_len_odd));
      r_idx        <= w_start ? '0 : w_idx_next;
      r_beat       <= w_start ? 1'b1 : !r_beat;
      r_step_pulse <= 1'b1;
    end else begin
      r_step_pulse <= 1'b0;
      if (w_tick) r_tick_cnt <= w_tick_cnt_inc;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DIV_W-1:0] r_k;
    logic             r_pulse;
    logic [DIV_W-1:0] w_div;

    assign w_div = bus.CH_DIV[c*DIV_W +: DIV_W];

    // >= rather than == so a divisor lowered below the count fires next step.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_k     <= '0;
        r_pulse <= 1'b0;
      end else if (!bus.RUN) begin
        r_k     <= '0;
        r_pulse <= 1'b0;
      end else if (w_start) begin
        r_k     <= '0;
        r_pulse <= 1'b1;
      end else if (w_step) begin
        if (r_k >= w_div) begin
          r_k     <= '0;
          r_pulse <= 1'b1;
        end else begin
          r_k     <= r_k + 1'b1;
          r_pulse <= 1'b0;
        end
      end else begin
        r_pulse <= 1'b0;
      end
    end

    assign w_ch_pulse[c] = r_pulse;
  end

  assign bus.TICK       = w_tick;
  assign bus.STEP_PULSE = r_step_pulse;
  assign bus.STEP_INDEX = r_idx;
  assign bus.BEAT_CLOCK = r_beat;
  assign bus.CH_PULSE   = w_ch_pulse;

endmodule

// File: tb/tb_beat_step_clock.sv
// Bench for beat_step_clock: timing-rule reference model checked every cycle,
// a table of step-interval vectors, and hand-written corner sequences.
module tb_beat_step_clock;

  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int TDIV = CLK_HZ / TICK_HZ;
  localparam int PW = 8;
  localparam int STEPS = 4;
  localparam int CH = 2;
  localparam int DW = 4;

  logic clk;
  logic rst_n;

  beat_step_clock_if #(.PERIOD_W(PW), .STEPS(STEPS), .CHANNELS(CH), .DIV_W(DW)) bus ();

  beat_step_clock #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .PERIOD_W (PW),
    .STEPS    (STEPS),
    .CHANNELS (CH),
    .DIV_W    (DW)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s t=%0t got 0x%0h want 0x%0h", name, $time, act, exp);
  endtask

  typedef struct {
    int period;
    int swing;
    int first_iv;
    int odd_iv;
    int even_iv;
  } vec_t;

  // Reference model: step start times derived from the tick grid anchored at
  // the downbeat; a step whose L-th tick lands at cycle T starts at T+1.
  bit m_active;
  int m_n, m_next, m_steps;
  int m_k[CH];
  int e_tick, e_pulse, e_idx, e_beat, e_ch;

  function automatic int ref_len(input int p, input int s, input int odd);
    int pp;
    int ss;
    pp = (p == 0) ? 1 : p;
    ss = (s > pp - 1) ? pp - 1 : s;
    return (odd != 0) ? pp - ss : pp + ss;
  endfunction

  task automatic model_clear();
    m_active = 0;
    e_tick = 0; e_pulse = 0; e_idx = 0; e_beat = 0; e_ch = 0;
    for (int c = 0; c < CH; c++) m_k[c] = 0;
  endtask

  task automatic model_edge();
    int d;
    if (!rst_n || !bus.RUN) begin
      model_clear();
    end else if (!m_active) begin
      m_active = 1;
      m_n = 0;
      m_steps = 0;
      m_next = TDIV * ref_len(int'(bus.PERIOD), int'(bus.SWING), 0) + 1;
      e_tick = 0; e_pulse = 1; e_idx = 0; e_beat = 1; e_ch = (1 << CH) - 1;
      for (int c = 0; c < CH; c++) m_k[c] = 0;
    end else begin
      m_n++;
      e_tick = (m_n % TDIV == 0) ? 1 : 0;
      if (m_n == m_next) begin
        m_steps++;
        e_idx = m_steps % STEPS;
        e_beat = (m_steps % 2 == 0) ? 1 : 0;
        m_next = TDIV * (m_n / TDIV + ref_len(int'(bus.PERIOD), int'(bus.SWING), e_idx % 2)) + 1;
        e_pulse = 1;
        e_ch = 0;
        for (int c = 0; c < CH; c++) begin
          d = int'((bus.CH_DIV >> (c * DW)) & 8'h0f);
          if (m_k[c] >= d) begin
            e_ch |= (1 << c);
            m_k[c] = 0;
          end else begin
            m_k[c]++;
          end
        end
      end else begin
        e_pulse = 0;
        e_ch = 0;
      end
    end
  endtask

  function automatic int pack_out();
    return int'({25'd0, bus.TICK, bus.STEP_PULSE, bus.STEP_INDEX, bus.BEAT_CLOCK, bus.CH_PULSE});
  endfunction

  function automatic int pack_exp();
    return e_tick * 64 + e_pulse * 32 + e_idx * 8 + e_beat * 4 + e_ch;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("outputs", pack_out(), pack_exp());
  endtask

  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.STEP_PULSE && n < limit);
    chk("pulse_seen", int'(bus.STEP_PULSE), 1);
  endtask

  task automatic do_reset();
    bus.RUN = 1'b0;
    rst_n = 1'b0;
    model_clear();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic start(input int p, input int s, input int div);
    int n;
    do_reset();
    bus.PERIOD = PW'(p);
    bus.SWING = PW'(s);
    bus.CH_DIV = (CH * DW)'(div);
    bus.RUN = 1'b1;
    wait_pulse(5, n);
    chk("downbeat_latency", n, 1);
    chk("downbeat_index", int'(bus.STEP_INDEX), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int n, acc, seen, pat0, pat1;

    vecs[0] = '{3, 0, 31, 30, 30};
    vecs[1] = '{4, 2, 61, 20, 60};
    vecs[2] = '{4, 9, 71, 10, 70};
    vecs[3] = '{0, 0, 11, 10, 10};
    vecs[4] = '{1, 0, 11, 10, 10};
    vecs[5] = '{5, 4, 91, 10, 90};
    vecs[6] = '{255, 255, 5091, 10, 5090};

    rst_n = 1'b0;
    bus.RUN = 1'b0;
    bus.PERIOD = '0;
    bus.SWING = '0;
    bus.CH_DIV = '0;
    model_clear();
    #1;
    chk("reset_state", pack_out(), 0);

    for (int i = 0; i < 7; i++) begin
      start(vecs[i].period, vecs[i].swing, 0);
      wait_pulse(6000, n);
      chk("first_interval", n, vecs[i].first_iv);
      wait_pulse(6000, n);
      chk("odd_interval", n, vecs[i].odd_iv);
      wait_pulse(6000, n);
      chk("even_interval", n, vecs[i].even_iv);
    end

    // PERIOD change mid-step only affects the following step.
    start(3, 0, 0);
    for (int i = 0; i < 15; i++) cyc();
    bus.PERIOD = 8'd5;
    wait_pulse(100, n);
    chk("midstep_period_kept", n + 15, 31);
    wait_pulse(100, n);
    chk("midstep_period_next", n, 50);

    // RUN low just before a step is due: pending step is dropped.
    start(3, 0, 0);
    for (int i = 0; i < 25; i++) cyc();
    bus.RUN = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      seen += int'(bus.STEP_PULSE);
    end
    chk("no_pulse_while_low", seen, 0);
    bus.RUN = 1'b1;
    cyc();
    chk("restart_pulse", int'(bus.STEP_PULSE), 1);
    chk("restart_index", int'(bus.STEP_INDEX), 0);

    // Channel dividers: ch1 every third step, ch0 every step.
    start(1, 0, 8'h20);
    pat0 = int'(bus.CH_PULSE[0]);
    pat1 = int'(bus.CH_PULSE[1]);
    for (int i = 1; i < 7; i++) begin
      wait_pulse(20, n);
      pat0 |= int'(bus.CH_PULSE[0]) << i;
      pat1 |= int'(bus.CH_PULSE[1]) << i;
    end
    chk("ch0_pattern", pat0, 7'b1111111);
    chk("ch1_pattern", pat1, 7'b1001001);
    bus.CH_DIV = 8'h50;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(20, n);
      acc += int'(bus.CH_PULSE[1]);
    end
    chk("ch1_no_fire_counting", acc, 0);
    bus.CH_DIV = 8'h10;
    wait_pulse(20, n);
    chk("ch1_div_drop_fires", int'(bus.CH_PULSE[1]), 1);

    // Asynchronous reset mid-step, RUN held high through release.
    start(3, 0, 0);
    for (int i = 0; i < 12; i++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", pack_out(), 0);
    model_clear();
    cyc();
    rst_n = 1'b1;
    wait_pulse(5, n);
    chk("post_reset_downbeat", n, 1);
    chk("post_reset_index", int'(bus.STEP_INDEX), 0);
    wait_pulse(100, n);
    chk("post_reset_interval", n, 31);

    // Randomised run against the reference model.
    do_reset();
    bus.RUN = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        bus.PERIOD = PW'($urandom_range(0, 4));
        bus.SWING = PW'($urandom_range(0, 5));
        bus.CH_DIV = (CH * DW)'($urandom);
        bus.RUN = ($urandom_range(0, 9) != 0);
      end else if (!bus.RUN) begin
        bus.RUN = 1'b1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/beat_step_clock.md
Name: beat_step_clock

Overview:
- Parametrised tempo generator and next generation of the 100 Hz beat clock, with the base-tick prescaler built in.
- Derives a base tick from CLOCK_50, counts ticks into sequencer steps of programmable length with optional swing, and emits a step pulse, step index and square-wave beat level.
- Emits one-cycle pulses on CHANNELS independent step dividers.
- Feeds the sequencer step engine and per-track triggers.

Parameters:
- CLK_HZ, 50000000: input clock frequency.
- TICK_HZ, 100: base tick rate. TICK_DIV = CLK_HZ/TICK_HZ must be >= 2.
- PERIOD_W, 8: width of PERIOD and SWING, in ticks.
- STEPS, 16: step-index wrap count, >= 2, power of 2 not required.
- CHANNELS, 4: number of divided trigger channels.
- DIV_W, 4: width of each channel divisor.

Ports:
- CLOCK_50  in  1  system clock
- RESET_N  in  1  reset; one clock; reset is asynchronous and active-low
- RUN  in  1  1 = running, 0 = stopped and cleared
- PERIOD  in  PERIOD_W  ticks per step; 0 treated as 1
- SWING  in  PERIOD_W  ticks added to even steps and removed from odd steps
- CH_DIV  in  CHANNELS*DIV_W  channel c divisor at bits [c*DIV_W +: DIV_W]; channel fires every (CH_DIV_c+1) steps
- TICK  out  1  one-cycle pulse per base tick while running
- STEP_PULSE  out  1  one-cycle pulse at each step start
- STEP_INDEX  out  $clog2(STEPS)  current step, 0..STEPS-1
- BEAT_CLOCK  out  1  toggles at each step start
- CH_PULSE  out  CHANNELS  one-cycle per-channel trigger, coincident with STEP_PULSE

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs 0 and all counters 0.
- Stopped (RUN sampled 0):
  - Same cleared state as reset, held synchronously.
  - No pulses are generated.
- Start:
  - The first cycle RUN is sampled 1 after being 0 is the start edge.
  - On the next cycle: STEP_PULSE=1, STEP_INDEX=0, BEAT_CLOCK=1, and every CH_PULSE bit is 1. This is the immediate downbeat.
- Prescaler:
  - Counter 0..TICK_DIV-1; TICK is asserted the cycle it wraps.
  - Counter is cleared at the start edge, so the first TICK arrives TICK_DIV cycles after the downbeat.
- Step length:
  - Latched at each step start: L = P + S for even STEP_INDEX, L = P - S for odd.
  - P = max(PERIOD,1). S = min(SWING, P-1), so L is always >= 1 and every step pair totals 2P ticks.
  - Tick counter counts TICKs since step start. When it reaches L, the next step starts: STEP_PULSE for one cycle, the cycle after that TICK.
- Step index: increments modulo STEPS. STEPS-1 wraps to 0.
- Parameter updates: PERIOD, SWING and CH_DIV changes take effect only at the next step start, never mid-step.
- Channels:
  - Per-channel counter k_c is cleared at start.
  - At each step start: if k_c == CH_DIV_c, pulse CH_PULSE[c] and set k_c=0; otherwise k_c += 1.
  - At start, all channels pulse and every k_c is set to 0.
  - If CH_DIV_c drops below the current k_c, the channel fires at the next step and resets.
- Mid-step stop: RUN falling clears everything the following cycle. A pending step is discarded, not emitted.
- Simultaneous RUN rise and TICK: the start edge wins and the prescaler restarts.
- Widths:
  - L is computed in PERIOD_W+1 bits, so no overflow at PERIOD=max with SWING=max.
  - Tick counter is PERIOD_W+1 bits.
- Outputs are registered. No combinational input-to-output paths.

Decomposition:
- Shared package beat_pkg holds:
  - TICK_DIV
  - the clog2 width constants: PRE_W, IDX_W
  - step-length function step_len(period, swing, odd)
- Sub-module tick_prescaler (CLOCK_50, RESET_N, CLR, TICK) for the base divider. The top holds the step/swing FSM and the channel dividers via a generate loop.

Test Plan (CLK_HZ=1000, TICK_HZ=100 so TICK_DIV=10, STEPS=4, CHANNELS=2):
1. Reset then RUN=1, PERIOD=3, SWING=0 -> STEP_PULSE at cycle 1 and then every 30 cycles. STEP_INDEX runs 0,1,2,3,0. BEAT_CLOCK toggles at each step.
2. PERIOD=4, SWING=2 -> step intervals alternate 60, 20, 60, 20 cycles. SWING=9 clamps to 3, giving 70, 10.
3. PERIOD=0 -> step every 10 cycles, same as PERIOD=1. Change PERIOD 3 -> 5 mid-step -> current step stays 30 cycles, next step 50.
4. CH_DIV={ch1=2, ch0=0} -> CH_PULSE[0] on every step; CH_PULSE[1] on steps 0,3,6,... Both pulse at the downbeat.
5. RUN low 5 cycles before a step is due, then high -> no STEP_PULSE while low. Restart emits STEP_INDEX=0 one cycle after RUN rises.
6. RESET_N asserted asynchronously mid-step -> all outputs 0 immediately, without a clock edge. After release with RUN=1 held, the downbeat follows as in scenario 1.
